example_sdiv_seq_1rcu: RTL and testbench



---
 rtl/example_sdiv_seq_1rcu.sv | 185 ++++++++++++++++++
 tb/tb_example_sdiv_seq_1rcu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/example_sdiv_seq_1rcu.sv
// Sequential signed divider (restoring, MSB first) with ap_ block handshake.
// Quotient truncates toward zero, saturates to dout_WIDTH; remainder takes the dividend's sign.
module example_sdiv_seq_1rcu #(
  parameter int din0_WIDTH = 20,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int AW = din0_WIDTH + 1;
  localparam int PW = din1_WIDTH + 1;
  localparam int CW = $clog2(din0_WIDTH);
  localparam logic [CW-1:0]         CNT_LAST = CW'(din0_WIDTH - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [din0_WIDTH-1:0] POS_LIM  = din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
  localparam logic [din0_WIDTH-1:0] NEG_LIM  = din0_WIDTH'(64'd1 << (dout_WIDTH - 1));
  localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic [AW-1:0]           a_q;
  logic [din1_WIDTH-1:0]   b_q;
  logic                    sa_q;
  logic                    sb_q;
  logic                    zero_q;
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           pr_q;
  logic [din0_WIDTH-1:0]   uq_q;
  logic [dout_WIDTH-1:0]   dout_q;
  logic [din1_WIDTH-1:0]   rem_q;
  logic                    dbz_q;
  logic                    ovf_q;
  logic                    done_q;
  logic                    idle_q;

  logic [AW-1:0]           a_abs_d;
  logic [din1_WIDTH-1:0]   b_abs_d;
  logic [PW:0]             pr_shift_d;
  logic [PW:0]             sub_d;
  logic                    borrow_d;
  logic [PW-1:0]           pr_d;
  logic                    qbit_d;
  logic [din0_WIDTH-1:0]   uq_neg_d;
  logic [din1_WIDTH-1:0]   ur_d;
  logic [dout_WIDTH-1:0]   dout_fix_d;
  logic [din1_WIDTH-1:0]   rem_fix_d;
  logic                    dbz_fix_d;
  logic                    ovf_fix_d;

  // Operand magnitudes and one restoring-division step
  always_comb begin
    a_abs_d    = din0[din0_WIDTH-1] ? (AW'(0) - {1'b1, din0}) : {1'b0, din0};
    b_abs_d    = din1[din1_WIDTH-1] ? (din1_WIDTH'(0) - din1) : din1;
    pr_shift_d = {pr_q, a_q[din0_WIDTH-1]};
    sub_d      = pr_shift_d - {2'b00, b_q};
    borrow_d   = (pr_shift_d < {2'b00, b_q});
    pr_d       = borrow_d ? PW'(pr_shift_d) : PW'(sub_d);
    qbit_d     = ~borrow_d;
  end

  // Sign restoration, saturation and divide-by-zero policy for the result registers
  always_comb begin
    uq_neg_d  = din0_WIDTH'(0) - uq_q;
    ur_d      = pr_q[din1_WIDTH-1:0];
    rem_fix_d = sa_q ? (din1_WIDTH'(0) - ur_d) : ur_d;
    dbz_fix_d = 1'b0;
    ovf_fix_d = 1'b0;
    dout_fix_d = dout_WIDTH'(uq_q);
    if (zero_q) begin
      dout_fix_d = sa_q ? DOUT_MIN : DOUT_MAX;
      rem_fix_d  = {din1_WIDTH{1'b0}};
      dbz_fix_d  = 1'b1;
    end else if (sa_q ^ sb_q) begin
      if (uq_q > NEG_LIM) begin
        dout_fix_d = DOUT_MIN;
        ovf_fix_d  = 1'b1;
      end else begin
        dout_fix_d = dout_WIDTH'(uq_neg_d);
      end
    end else begin
      if (uq_q > POS_LIM) begin
        dout_fix_d = DOUT_MAX;
        ovf_fix_d  = 1'b1;
      end else begin
        dout_fix_d = dout_WIDTH'(uq_q);
      end
    end
  end

  // Control FSM with datapath and registered outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= {AW{1'b0}};
      b_q     <= {din1_WIDTH{1'b0}};
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      pr_q    <= {PW{1'b0}};
      uq_q    <= {din0_WIDTH{1'b0}};
      dout_q  <= {dout_WIDTH{1'b0}};
      rem_q   <= {din1_WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            a_q     <= a_abs_d;
            b_q     <= b_abs_d;
            sa_q    <= din0[din0_WIDTH-1];
            sb_q    <= din1[din1_WIDTH-1];
            zero_q  <= (din1 == {din1_WIDTH{1'b0}});
            cnt_q   <= {CW{1'b0}};
            pr_q    <= {PW{1'b0}};
            uq_q    <= {din0_WIDTH{1'b0}};
            idle_q  <= 1'b0;
            state_q <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          a_q  <= a_q << 1;
          pr_q <= pr_d;
          uq_q <= {uq_q[din0_WIDTH-2:0], qbit_d};
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FIX: begin
          dout_q  <= dout_fix_d;
          rem_q   <= rem_fix_d;
          dbz_q   <= dbz_fix_d;
          ovf_q   <= ovf_fix_d;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ap_ready    = ap_start & (state_q == S_IDLE);
  assign ap_idle     = idle_q;
  assign ap_done     = done_q;
  assign dout        = dout_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_example_sdiv_seq_1rcu.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus literal expectations.
module tb_example_sdiv_seq_1rcu;

  typedef struct packed {
    logic signed [13:0] q;
    logic signed [5:0]  r;
    logic               dbz;
    logic               ovf;
  } res_t;

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [19:0] din0 = 20'd0;
  logic [5:0]  din1 = 6'd0;
  logic [13:0] dout;
  logic [5:0]  rem;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  example_sdiv_seq_1rcu #(
    .din0_WIDTH(20),
    .din1_WIDTH(6),
    .dout_WIDTH(14)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_idle(ap_idle),
    .ap_done(ap_done),
    .din0(din0),
    .din1(din1),
    .dout(dout),
    .rem(rem),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // C semantics: truncating division, remainder takes the dividend's sign
  function automatic res_t model_div(input logic [19:0] a, input logic [5:0] b);
    res_t   r;
    longint la;
    longint lb;
    longint lq;
    r  = '0;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) begin
      r.q   = (la >= 0) ? 14'h1FFF : 14'h2000;
      r.dbz = 1'b1;
    end else begin
      lq  = la / lb;
      r.r = 6'(la % lb);
      if (lq > 8191) begin
        r.q   = 14'h1FFF;
        r.ovf = 1'b1;
      end else if (lq < -8192) begin
        r.q   = 14'h2000;
        r.ovf = 1'b1;
      end else begin
        r.q = 14'(lq);
      end
    end
    return r;
  endfunction

  logic m_busy = 1'b0;
  int   m_cnt  = 0;
  res_t m_pend = '0;
  res_t m_res  = '0;

  // Reference model: busy for cycles 1..22 after accept, results appear in cycle 22
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_busy) begin
      if (ap_start) begin
        m_pend <= model_div(din0, din1);
        m_busy <= 1'b1;
        m_cnt  <= 1;
      end
    end else if (m_cnt == 22) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 21) m_res <= m_pend;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge ap_clk) begin
    chk("idle",  ap_idle,  !m_busy);
    chk("ready", ap_ready, ap_start && !m_busy);
    chk("done",  ap_done,  m_busy && (m_cnt == 22));
    chk("dout",  $signed(dout), m_res.q);
    chk("rem",   $signed(rem),  m_res.r);
    chk("dbz",   div_by_zero, m_res.dbz);
    chk("ovf",   overflow,    m_res.ovf);
  end

  task automatic do_op(input int a, input int b, input bit lit, input int eq, input int er,
                       input bit edbz, input bit eovf, input bit pulse);
    int lat;
    @(posedge ap_clk); #1;
    din0 = 20'(a);
    din1 = 6'(b);
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    din0 = 20'($urandom);
    din1 = 6'($urandom);
    lat = 1;
    while (!ap_done && lat < 40) begin
      @(posedge ap_clk); #1;
      lat++;
      if (pulse && lat == 5) ap_start = 1'b1;
      if (lat == 7) ap_start = 1'b0;
    end
    chk("latency", lat, 22);
    if (lit) begin
      chk("lit_dout", $signed(dout), eq);
      chk("lit_rem",  $signed(rem),  er);
      chk("lit_dbz",  div_by_zero, edbz);
      chk("lit_ovf",  overflow,    eovf);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t pin;
    int   t;
    int   nd;
    int   ra;
    int   rb;

    pin = model_div(20'd1000, 6'd7);
    chk("pin_q", pin.q, 142);
    chk("pin_r", pin.r, 6);
    pin = model_div(20'(-1000), 6'(-7));
    chk("pin_nq", pin.q, 142);
    chk("pin_nr", pin.r, -6);

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_idle", ap_idle, 1);
    chk("rst_dout", dout, 0);
    chk("rst_done", ap_done, 0);
    ap_rst_n = 1'b1;

    do_op(1000, 7, 1'b1, 142, 6, 1'b0, 1'b0, 1'b0);
    do_op(-1000, 7, 1'b1, -142, -6, 1'b0, 1'b0, 1'b0);
    do_op(1000, -7, 1'b1, -142, 6, 1'b0, 1'b0, 1'b0);
    do_op(-1000, -7, 1'b1, 142, -6, 1'b0, 1'b0, 1'b0);
    do_op(-524288, -32, 1'b1, 8191, 0, 1'b0, 1'b1, 1'b0);
    do_op(524287, 1, 1'b1, 8191, 0, 1'b0, 1'b1, 1'b0);
    do_op(-524288, 1, 1'b1, -8192, 0, 1'b0, 1'b1, 1'b0);
    do_op(-8192, 1, 1'b1, -8192, 0, 1'b0, 1'b0, 1'b0);
    do_op(5, 0, 1'b1, 8191, 0, 1'b1, 1'b0, 1'b0);
    do_op(-5, 0, 1'b1, -8192, 0, 1'b1, 1'b0, 1'b0);
    do_op(10, 3, 1'b1, 3, 1, 1'b0, 1'b0, 1'b1);

    // start held high across two operations
    @(posedge ap_clk); #1;
    din0 = 20'd300;
    din1 = 6'd5;
    ap_start = 1'b1;
    t = 0;
    while (!ap_done && t < 40) begin @(posedge ap_clk); #1; t++; end
    chk("held_first", t, 22);
    din0 = 20'(-777);
    din1 = 6'd9;
    t = 0;
    do begin @(posedge ap_clk); #1; t++; end while (!ap_done && t < 40);
    chk("held_period", t, 23);
    chk("held_dout", $signed(dout), -86);
    chk("held_rem",  $signed(rem),  -3);
    ap_start = 1'b0;

    // reset in the middle of CALC
    @(posedge ap_clk); #1;
    din0 = 20'd12345;
    din1 = 6'd3;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (9) begin @(posedge ap_clk); #1; end
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_idle", ap_idle, 1);
    chk("mid_rst_done", ap_done, 0);
    ap_rst_n = 1'b1;
    nd = 0;
    repeat (25) begin
      @(posedge ap_clk); #1;
      if (ap_done) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    do_op(100, -9, 1'b1, -11, 1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = -524288;
        1:       ra = 524287;
        2:       ra = int'($urandom_range(0, 2000)) - 1000;
        default: ra = int'($urandom);
      endcase
      rb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 63));
      do_op(ra, rb, 1'b0, 0, 0, 1'b0, 1'b0, i[0]);
    end

    repeat (3) @(posedge ap_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
